// File: rtl/sodor_imem_pkg.sv
// Shared types and constants for the Sodor instruction-memory responder.
package sodor_imem_pkg;

  // RISC-V canonical NOP (addi x0, x0, 0).
  localparam logic [31:0] NOP = 32'h0000_0013;

  // Deepest fixed latency the responder supports.
  localparam int LATENCY_MAX = 4;

  // One fetch response: instruction word plus misalignment flag.
  typedef struct packed {
    logic [31:0] data;
    logic        fault;
  } imem_resp_t;

endpackage

// File: rtl/sodor_imem_fifo.sv
// Response FIFO. The pointers carry one extra wrap bit, so equal pointers
// mean empty. The caller's credit counter guarantees that a push never
// happens while the FIFO is full, so no full flag is needed.
module sodor_imem_fifo
  import sodor_imem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  imem_resp_t push_data,
  input  logic       pop,
  output imem_resp_t head,
  output logic       empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  imem_resp_t     mem_reg [DEPTH];
  logic [AW:0]    wr_ptr_reg;
  logic [AW:0]    rd_ptr_reg;

  // Pointer advance; the reset clears both pointers, which empties the FIFO.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Entry storage; the contents need no reset because empty gates visibility.
  always_ff @(posedge clock) begin
    if (push) mem_reg[wr_ptr_reg[AW-1:0]] <= push_data;
  end

  assign head  = mem_reg[rd_ptr_reg[AW-1:0]];
  assign empty = (wr_ptr_reg == rd_ptr_reg);

endmodule

// File: rtl/sodor_imem_responder.sv
// Fetch-side instruction memory: a small program store with a side load port,
// a fixed-latency read pipeline and a credit-limited in-order response FIFO.
module sodor_imem_responder
  import sodor_imem_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int LATENCY    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [31:0]                   req_addr,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [31:0]                   resp_data,
  output logic                          resp_fault,
  input  logic                          load_en,
  input  logic [$clog2(DEPTH)-1:0]      load_idx,
  input  logic [31:0]                   load_data,
  output logic [$clog2(FIFO_DEPTH):0]   outstanding
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]        store_reg [DEPTH];
  logic [CNT_W-1:0]   outstanding_reg;
  logic               accept;
  logic               pop;
  logic [IDX_W-1:0]   req_idx;
  imem_resp_t         req_entry;
  imem_resp_t         fifo_head;
  logic               fifo_empty;
  logic               unused_addr_bits;

  // Entry i of the chain holds a response accepted i cycles ago; entry 0 is
  // the response being accepted right now. The last entry feeds the FIFO, whose
  // own write register provides the final cycle of latency.
  logic               chain_valid [LATENCY];
  imem_resp_t         chain_entry [LATENCY];

  assign req_ready = (outstanding_reg < CNT_W'(FIFO_DEPTH));
  assign accept    = req_valid && req_ready;
  assign pop       = resp_valid && resp_ready;
  assign req_idx   = req_addr[IDX_W+1:2];

  // Upper address bits alias onto the store and are intentionally ignored.
  assign unused_addr_bits = ^req_addr[31:IDX_W+2];

  // Read the store at accept time; misaligned fetches return a faulting NOP.
  always_comb begin
    req_entry.data  = store_reg[req_idx];
    req_entry.fault = 1'b0;
    if (req_addr[1:0] != 2'b00) begin
      req_entry.data  = NOP;
      req_entry.fault = 1'b1;
    end
  end

  // Program store: cleared to NOP on reset, written by the load port. A load
  // and a read of the same word in one cycle return the old word.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) store_reg[i] <= NOP;
    end else if (load_en) begin
      store_reg[load_idx] <= load_data;
    end
  end

  assign chain_valid[0] = accept;
  assign chain_entry[0] = req_entry;

  genvar gi;
  generate
    for (gi = 1; gi < LATENCY; gi++) begin : g_stage
      // Shift one latency stage per clock; reset drops in-flight responses.
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          chain_valid[gi] <= 1'b0;
          chain_entry[gi] <= '0;
        end else begin
          chain_valid[gi] <= chain_valid[gi-1];
          chain_entry[gi] <= chain_entry[gi-1];
        end
      end
    end
  endgenerate

  sodor_imem_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (chain_valid[LATENCY-1]),
    .push_data (chain_entry[LATENCY-1]),
    .pop       (pop),
    .head      (fifo_head),
    .empty     (fifo_empty)
  );

  // Credit counter covering both the latency pipeline and the FIFO.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      outstanding_reg <= '0;
    end else if (accept && !pop) begin
      outstanding_reg <= outstanding_reg + 1'b1;
    end else if (!accept && pop) begin
      outstanding_reg <= outstanding_reg - 1'b1;
    end
  end

  assign outstanding = outstanding_reg;
  assign resp_valid  = !fifo_empty;
  assign resp_data   = fifo_empty ? 32'h0 : fifo_head.data;
  assign resp_fault  = fifo_empty ? 1'b0  : fifo_head.fault;

endmodule

// File: tb/tb_sodor_imem_responder.sv
// Bench: drives a LATENCY=1 and a LATENCY=3 responder with identical stimulus
// and compares both every cycle against a queue-of-pending-responses model.
module tb_sodor_imem_responder;

  localparam logic [31:0] NOP_W = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic        resp_ready = 1'b0;
  logic        load_en = 1'b0;
  logic [3:0]  load_idx = '0;
  logic [31:0] load_data = '0;

  logic        a_req_ready, a_resp_valid, a_resp_fault;
  logic [31:0] a_resp_data;
  logic [2:0]  a_outstanding;
  logic        b_req_ready, b_resp_valid, b_resp_fault;
  logic [31:0] b_resp_data;
  logic [2:0]  b_outstanding;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Reference model: program store plus, per instance, a ring of pending
  // responses each tagged with the cycle in which it becomes visible.
  logic [31:0] store_m [16];
  logic [31:0] m_data  [2][8];
  logic        m_fault [2][8];
  int          m_rdy   [2][8];
  int          m_head  [2];
  int          m_cnt   [2];

  always #5 clock = ~clock;

  sodor_imem_responder #(.DEPTH(16), .LATENCY(1), .FIFO_DEPTH(4)) u_dut_a (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(a_req_ready), .req_addr(req_addr),
    .resp_valid(a_resp_valid), .resp_ready(resp_ready),
    .resp_data(a_resp_data), .resp_fault(a_resp_fault),
    .load_en(load_en), .load_idx(load_idx), .load_data(load_data),
    .outstanding(a_outstanding)
  );

  sodor_imem_responder #(.DEPTH(16), .LATENCY(3), .FIFO_DEPTH(4)) u_dut_b (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(b_req_ready), .req_addr(req_addr),
    .resp_valid(b_resp_valid), .resp_ready(resp_ready),
    .resp_data(b_resp_data), .resp_fault(b_resp_fault),
    .load_en(load_en), .load_idx(load_idx), .load_data(load_data),
    .outstanding(b_outstanding)
  );

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) store_m[i] = NOP_W;
    for (int k = 0; k < 2; k++) begin
      m_head[k] = 0;
      m_cnt[k]  = 0;
    end
  endtask

  function automatic logic head_visible(input int k);
    return (m_cnt[k] > 0) && (m_rdy[k][m_head[k]] <= cyc);
  endfunction

  task automatic check_inst(input int k, input logic rdy, input logic vld,
                            input logic [31:0] data, input logic flt, input logic [2:0] outs);
    logic ev;
    ev = head_visible(k);
    chk($sformatf("L%0d req_ready c%0d", lat(k), cyc), {31'b0, rdy}, {31'b0, (m_cnt[k] < 4)});
    chk($sformatf("L%0d resp_valid c%0d", lat(k), cyc), {31'b0, vld}, {31'b0, ev});
    chk($sformatf("L%0d outstanding c%0d", lat(k), cyc), {29'b0, outs}, 32'(m_cnt[k]));
    if (ev) begin
      chk($sformatf("L%0d resp_data c%0d", lat(k), cyc), data, m_data[k][m_head[k]]);
      chk($sformatf("L%0d resp_fault c%0d", lat(k), cyc), {31'b0, flt}, {31'b0, m_fault[k][m_head[k]]});
    end
  endtask

  task automatic check_all();
    check_inst(0, a_req_ready, a_resp_valid, a_resp_data, a_resp_fault, a_outstanding);
    check_inst(1, b_req_ready, b_resp_valid, b_resp_data, b_resp_fault, b_outstanding);
  endtask

  // One clock cycle: apply inputs, advance the model across the edge, check.
  task automatic step(input logic rv, input logic [31:0] a, input logic rr,
                      input logic le, input logic [3:0] li, input logic [31:0] ld);
    logic acc [2];
    logic pp  [2];
    int   slot;
    req_valid = rv; req_addr = a; resp_ready = rr;
    load_en = le; load_idx = li; load_data = ld;
    for (int k = 0; k < 2; k++) begin
      acc[k] = rv && (m_cnt[k] < 4);
      pp[k]  = rr && head_visible(k);
    end
    @(posedge clock);
    for (int k = 0; k < 2; k++) begin
      if (pp[k]) begin
        if (k == 0)
          $display("c%0d L1 resp %h fault %0d", cyc, m_data[k][m_head[k]], m_fault[k][m_head[k]]);
        m_head[k] = (m_head[k] + 1) % 8;
        m_cnt[k]--;
      end
      if (acc[k]) begin
        slot = (m_head[k] + m_cnt[k]) % 8;
        m_fault[k][slot] = (a[1:0] != 2'b00);
        m_data[k][slot]  = m_fault[k][slot] ? NOP_W : store_m[a[5:2]];
        m_rdy[k][slot]   = cyc + lat(k);
        m_cnt[k]++;
      end
    end
    if (le) store_m[li] = ld;
    cyc++;
    @(negedge clock);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0);
  endtask

  task automatic fetch(input logic [31:0] a, input logic rr);
    step(1'b1, a, rr, 1'b0, 4'h0, 32'h0);
  endtask

  initial begin
    logic [31:0] ra;
    model_reset();
    repeat (2) @(negedge clock);
    check_all();
    chk("reset resp_data", a_resp_data, 32'h0);
    chk("reset resp_fault", {31'b0, a_resp_fault}, 32'h0);
    reset = 1'b1;

    // Load then fetch aligned, misaligned and aliased addresses.
    step(1'b0, 32'h0, 1'b1, 1'b1, 4'd3, 32'h0010_2223);
    fetch(32'h0000_000C, 1'b1);
    chk("tp aligned data", a_resp_data, 32'h0010_2223);
    fetch(32'h0000_000E, 1'b1);
    chk("tp misaligned data", a_resp_data, NOP_W);
    chk("tp misaligned fault", {31'b0, a_resp_fault}, 32'h1);
    fetch(32'h0000_004C, 1'b1);
    chk("tp alias data", a_resp_data, 32'h0010_2223);
    idle(4);

    // Back-pressure: credits run out after four accepts.
    for (int i = 0; i < 6; i++) fetch(32'(i * 4), 1'b0);
    chk("tp full outstanding", {29'b0, a_outstanding}, 32'd4);
    chk("tp full req_ready", {31'b0, a_req_ready}, 32'h0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0);
    chk("tp ready after pop", {31'b0, a_req_ready}, 32'h1);
    idle(6);

    // Same-cycle load and fetch of one word returns the old word.
    step(1'b1, 32'h0000_0014, 1'b1, 1'b1, 4'd5, 32'hDEAD_BEEF);
    chk("tp old word", a_resp_data, NOP_W);
    fetch(32'h0000_0014, 1'b1);
    chk("tp new word", a_resp_data, 32'hDEAD_BEEF);
    idle(4);

    // Eight back-to-back fetches at full throughput.
    for (int i = 0; i < 8; i++) fetch(32'(i * 4), 1'b1);
    chk("tp L3 outstanding peak", {29'b0, b_outstanding}, 32'd3);
    idle(5);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      ra = $urandom;
      if ($urandom_range(0, 7) != 0) ra[1:0] = 2'b00;
      step($urandom_range(0, 3) != 0, ra, $urandom_range(0, 9) < 7,
           $urandom_range(0, 7) == 0, 4'($urandom_range(0, 15)), $urandom);
    end
    idle(8);

    // Asynchronous reset with responses in flight.
    for (int i = 0; i < 3; i++) fetch(32'h0000_000C, 1'b0);
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("async rst L1 resp_valid", {31'b0, a_resp_valid}, 32'h0);
    chk("async rst L1 outstanding", {29'b0, a_outstanding}, 32'h0);
    chk("async rst L3 resp_valid", {31'b0, b_resp_valid}, 32'h0);
    chk("async rst L3 outstanding", {29'b0, b_outstanding}, 32'h0);
    chk("async rst req_ready", {31'b0, a_req_ready}, 32'h1);
    @(negedge clock);
    reset = 1'b1;
    fetch(32'h0000_000C, 1'b1);
    chk("post rst store data", a_resp_data, NOP_W);
    idle(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
